byte_serial_adder: RTL and testbench
====================================

// Module: byte_serial_adder
// PURPOSE
//  Adds two NBYTES-wide operands one byte per transfer, least-significant byte first.
//  Instantiates bitadder_8 for the per-byte add and feeds its carry-out back as the
//  next byte's carry-in through a register. The block drives bitadder_8's operands
//  and captures its S/cout, so wide adds reuse the existing 8-bit datapath.
// PARAMETERS
//  NBYTES  4  bytes per operand (>=1); counter width = clog2(NBYTES), minimum 1 bit
// PORTS
//  clk       in   1      rising-edge clock; the only clock
//  rst       in   1      synchronous, active-high reset
//  start     in   1      begin an operation; honoured only in IDLE
//  cin       in   1      initial carry-in, sampled on the cycle start is accepted
//  in_valid  in   1      a_byte/b_byte hold a valid byte pair
//  in_ready  out  1      block accepts a byte pair this cycle
//  a_byte    in   [0:7]  operand A byte; bit 7 is LSB, bit 0 is MSB
//  b_byte    in   [0:7]  operand B byte; same ordering
//  sum_byte  out  [0:7]  registered sum byte; same ordering
//  out_valid out  1      one-cycle pulse: sum_byte is valid
//  busy      out  1      high in RUN and DONE
//  done      out  1      one-cycle pulse: operation complete
//  cout      out  1      final carry-out; valid while done=1, then held until next start
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): state=IDLE; count=0; carry=0.
//   All outputs go to 0: in_ready, sum_byte, out_valid, busy, done, cout.
//   rst takes priority over every other input, including mid-operation; no partial result is emitted.
//  States: IDLE, RUN, DONE.
//  IDLE: in_ready=0; in_valid is ignored.
//   If start=1: carry<=cin, count<=0, cout<=0, next state RUN.
//  RUN: in_ready=1.
//   A byte transfers when in_valid=1 and in_ready=1. On a transfer:
//    {c,S} = a_byte + b_byte + carry (bitadder_8).
//    sum_byte<=S, out_valid<=1 next cycle, carry<=c, count<=count+1.
//  Latency: sum_byte/out_valid appear 1 cycle after the transfer.
//   With in_valid held high, one byte is accepted every cycle and out_valid pulses back to back.
//  Stall: when in_valid=0, nothing changes. carry, count and sum_byte hold; out_valid=0.
//  Completion: the transfer with count==NBYTES-1 moves state to DONE.
//   cout<=c on that transfer.
//  DONE: lasts exactly 1 cycle.
//   done=1; in_ready=0. The last out_valid pulse coincides with done.
//   Next state is IDLE unconditionally.
//  start asserted in RUN or DONE is ignored; it is not queued.
//  NBYTES=1: a single transfer goes directly RUN->DONE.
//  Arithmetic is unsigned modulo 2^(8*NBYTES); the carry beyond the MSB byte appears only on cout.
// CONFIGURATION
//  BSA_OVERFLOW_EN defined: adds output port ovf (1 bit).
//   ovf = two's-complement overflow of the MSB byte add:
//    (a[0]==b[0]) && (S[0]!=a[0]), using a_byte/b_byte/S of the final transfer (bit 0 = MSB).
//   ovf is registered with cout, has the same validity/hold rules, and resets to 0.
//  BSA_OVERFLOW_EN undefined: port ovf and its logic are absent.
//   All other behaviour is identical.
// TESTING
//  T1 NBYTES=4, cin=0, bytes LSB-first A=FF,00,00,00, B=01,00,00,00
//     -> sum_byte 00,01,00,00; cout=0; done 1 cycle after the 4th transfer.
//  T2 A=FFFFFFFF, B=00000001, cin=0 -> sum_byte 00,00,00,00; cout=1.
//  T3 A=0, B=0, cin=1 -> sum_byte 01,00,00,00; cout=0.
//  T4 T1 with in_valid=0 for 3 cycles between bytes 1 and 2
//     -> carry preserved; identical sums; out_valid only on accepted bytes; start pulsed in RUN ignored.
//  T5 rst=1 after 2 transfers of T2
//     -> next cycle all outputs 0, state IDLE; a fresh T3 then completes correctly.
//  T6 (BSA_OVERFLOW_EN) NBYTES=1, A=7F, B=01, cin=0 -> sum_byte=80, ovf=1, cout=0;
//     A=80, B=80 -> sum_byte=00, ovf=1, cout=1.

Source files
------------

// File: rtl/byte_serial_adder_if.sv
// Byte-serial adder bus: control, byte handshake and result signals.
// BSA_OVERFLOW_EN adds the ovf result flag.
interface byte_serial_adder_if;
  logic       start;
  logic       cin;
  logic       in_valid;
  logic       in_ready;
  logic [0:7] a_byte;
  logic [0:7] b_byte;
  logic [0:7] sum_byte;
  logic       out_valid;
  logic       busy;
  logic       done;
  logic       cout;
`ifdef BSA_OVERFLOW_EN
  logic       ovf;
`endif

  modport master (
    output start, cin, in_valid, a_byte, b_byte,
    input  in_ready, sum_byte, out_valid, busy, done,
`ifdef BSA_OVERFLOW_EN
    input  ovf,
`endif
    input  cout
  );

  modport slave (
    input  start, cin, in_valid, a_byte, b_byte,
    output in_ready, sum_byte, out_valid, busy, done,
`ifdef BSA_OVERFLOW_EN
    output ovf,
`endif
    output cout
  );
endinterface

// File: rtl/bitadder_8.sv
// 8-bit adder with carry in/out; bit 0 is the MSB, bit 7 the LSB.
module bitadder_8 (
  input  logic [0:7] a,
  input  logic [0:7] b,
  input  logic       cin,
  output logic [0:7] s,
  output logic       cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {8'b0, cin};
endmodule

// File: rtl/byte_serial_adder.sv
// Adds two NBYTES-wide operands one byte per transfer, LSB byte first, through bitadder_8.
// Define BSA_OVERFLOW_EN to add the ovf output (signed overflow of the final byte add).
module byte_serial_adder #(
  parameter int unsigned NBYTES = 4
) (
  input logic                 clk,
  input logic                 rst,
  byte_serial_adder_if.slave  bus
);
  localparam int unsigned CntW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] count_q;
  logic            carry_q;
  logic [0:7]      sum_q;
  logic            out_valid_q;
  logic            done_q;
  logic            cout_q;
  logic [0:7]      add_s;
  logic            add_c;
  logic            xfer;
  logic            last;

  bitadder_8 u_add (
    .a    (bus.a_byte),
    .b    (bus.b_byte),
    .cin  (carry_q),
    .s    (add_s),
    .cout (add_c)
  );

  assign xfer = (state_q == StRun) && bus.in_valid;
  assign last = (count_q == CntW'(NBYTES - 1));

`ifdef BSA_OVERFLOW_EN
  logic ovf_q;
  assign bus.ovf = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      count_q     <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      cout_q      <= 1'b0;
`ifdef BSA_OVERFLOW_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            carry_q <= bus.cin;
            count_q <= '0;
            cout_q  <= 1'b0;
`ifdef BSA_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
            state_q <= StRun;
          end
        end
        StRun: begin
          if (xfer) begin
            sum_q       <= add_s;
            out_valid_q <= 1'b1;
            carry_q     <= add_c;
            count_q     <= count_q + 1'b1;
            if (last) begin
              // done is registered so it lines up with the final out_valid pulse
              cout_q  <= add_c;
              done_q  <= 1'b1;
`ifdef BSA_OVERFLOW_EN
              ovf_q   <= (bus.a_byte[0] == bus.b_byte[0]) && (add_s[0] != bus.a_byte[0]);
`endif
              state_q <= StDone;
            end
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StRun);
  assign bus.busy      = (state_q == StRun) || (state_q == StDone);
  assign bus.sum_byte  = sum_q;
  assign bus.out_valid = out_valid_q;
  assign bus.done      = done_q;
  assign bus.cout      = cout_q;
endmodule

// File: tb/tb_byte_serial_adder.sv
// Self-checking bench for byte_serial_adder: NBYTES=4 and NBYTES=1 instances.
module tb_byte_serial_adder;
  localparam int unsigned NB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  byte_serial_adder_if bus0 ();
  byte_serial_adder_if bus1 ();

  byte_serial_adder #(.NBYTES(NB)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  byte_serial_adder #(.NBYTES(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int checks = 0;
  int passes = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] e0;
  logic [7:0] e1;

  // Scoreboards: every out_valid pulse must match the oldest pending expected byte.
  always @(negedge clk) begin
    if (bus0.out_valid === 1'b1) begin
      checks++;
      if (q0.size() == 0) begin
        $display("FAIL sb0: out_valid with no expected byte, got %h", bus0.sum_byte);
      end else begin
        e0 = q0.pop_front();
        if (bus0.sum_byte !== e0)
          $display("FAIL sb0 sum_byte: got %h expected %h", bus0.sum_byte, e0);
        else passes++;
      end
    end
    if (bus1.out_valid === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        $display("FAIL sb1: out_valid with no expected byte, got %h", bus1.sum_byte);
      end else begin
        e1 = q1.pop_front();
        if (bus1.sum_byte !== e1)
          $display("FAIL sb1 sum_byte: got %h expected %h", bus1.sum_byte, e1);
        else passes++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] obs0, obs1;
    rst = 1'b1;
    bus0.start = 0; bus0.cin = 0; bus0.in_valid = 0; bus0.a_byte = 0; bus0.b_byte = 0;
    bus1.start = 0; bus1.cin = 0; bus1.in_valid = 0; bus1.a_byte = 0; bus1.b_byte = 0;
    tick();
    tick();
    obs0 = {bus0.in_ready, bus0.out_valid, bus0.busy, bus0.done, bus0.cout, bus0.sum_byte};
    obs1 = {bus1.in_ready, bus1.out_valid, bus1.busy, bus1.done, bus1.cout, bus1.sum_byte};
    checks++;
    if (obs0 !== 13'h0) $display("FAIL reset bus0 outputs: got %h expected 0", obs0);
    else passes++;
    checks++;
    if (obs1 !== 13'h0) $display("FAIL reset bus1 outputs: got %h expected 0", obs1);
    else passes++;
`ifdef BSA_OVERFLOW_EN
    checks++;
    if ({bus0.ovf, bus1.ovf} !== 2'b00)
      $display("FAIL reset ovf: got %b expected 00", {bus0.ovf, bus1.ovf});
    else passes++;
`endif
    rst = 1'b0;
  endtask

  // Full NBYTES=4 operation; optional stall (with a start pulse) after byte stall_after.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input int stall_after, input int stall_len);
    logic [32:0] full;
    logic        exp_ovf;
    full    = {1'b0, a} + {1'b0, b} + {32'b0, c};
    exp_ovf = (a[31] == b[31]) && (full[31] != a[31]);
    bus0.cin   = c;
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    bus0.cin   = 1'b0;
    checks++;
    if ({bus0.busy, bus0.in_ready, bus0.done} !== 3'b110)
      $display("FAIL %s run entry busy/in_ready/done: got %b expected 110", name,
               {bus0.busy, bus0.in_ready, bus0.done});
    else passes++;
    for (int i = 0; i < NB; i++) begin
      bus0.a_byte   = a[8*i +: 8];
      bus0.b_byte   = b[8*i +: 8];
      bus0.in_valid = 1'b1;
      q0.push_back(full[8*i +: 8]);
      tick();
      if (i == stall_after) begin
        bus0.in_valid = 1'b0;
        bus0.start    = 1'b1;
        for (int k = 0; k < stall_len; k++) begin
          tick();
          bus0.start = 1'b0;
          checks++;
          if ({bus0.out_valid, bus0.in_ready, bus0.done} !== 3'b010)
            $display("FAIL %s stall out_valid/in_ready/done: got %b expected 010", name,
                     {bus0.out_valid, bus0.in_ready, bus0.done});
          else passes++;
        end
      end
    end
    bus0.in_valid = 1'b0;
    checks++;
    if ({bus0.done, bus0.out_valid, bus0.in_ready, bus0.busy} !== 4'b1101)
      $display("FAIL %s done cycle done/out_valid/in_ready/busy: got %b expected 1101", name,
               {bus0.done, bus0.out_valid, bus0.in_ready, bus0.busy});
    else passes++;
    checks++;
    if (bus0.cout !== full[32])
      $display("FAIL %s cout: got %b expected %b", name, bus0.cout, full[32]);
    else passes++;
`ifdef BSA_OVERFLOW_EN
    checks++;
    if (bus0.ovf !== exp_ovf)
      $display("FAIL %s ovf: got %b expected %b", name, bus0.ovf, exp_ovf);
    else passes++;
`endif
    tick();
    checks++;
    if ({bus0.done, bus0.busy, bus0.in_ready, bus0.cout} !== {3'b000, full[32]})
      $display("FAIL %s idle done/busy/in_ready/cout: got %b expected %b", name,
               {bus0.done, bus0.busy, bus0.in_ready, bus0.cout}, {3'b000, full[32]});
    else passes++;
    checks++;
    if (q0.size() != 0)
      $display("FAIL %s scoreboard pending: got %0d expected 0", name, q0.size());
    else passes++;
    tick();
    checks++;
    if (bus0.busy !== 1'b0)
      $display("FAIL %s queued start: busy got %b expected 0", name, bus0.busy);
    else passes++;
  endtask

  task automatic test_reset_mid();
    logic [12:0] obs;
    logic [32:0] full;
    full = {1'b0, 32'hFFFF_FFFF} + 33'd1;
    bus0.cin   = 1'b0;
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus0.a_byte   = 8'hFF;
      bus0.b_byte   = (i == 0) ? 8'h01 : 8'h00;
      bus0.in_valid = 1'b1;
      q0.push_back(full[8*i +: 8]);
      tick();
    end
    rst           = 1'b1;
    bus0.in_valid = 1'b0;
    tick();
    obs = {bus0.in_ready, bus0.out_valid, bus0.busy, bus0.done, bus0.cout, bus0.sum_byte};
    checks++;
    if (obs !== 13'h0) $display("FAIL reset_mid outputs: got %h expected 0", obs);
    else passes++;
    checks++;
    if (q0.size() != 0)
      $display("FAIL reset_mid pending: got %0d expected 0", q0.size());
    else passes++;
    rst = 1'b0;
    tick();
    run_op("T5_fresh_T3", 32'h0, 32'h0, 1'b1, -1, 0);
  endtask

  task automatic run_single(input string name, input logic [7:0] a, input logic [7:0] b,
                            input logic c, input logic exp_ovf);
    logic [8:0] full;
    full = {1'b0, a} + {1'b0, b} + {8'b0, c};
    bus1.cin   = c;
    bus1.start = 1'b1;
    tick();
    bus1.start    = 1'b0;
    bus1.a_byte   = a;
    bus1.b_byte   = b;
    bus1.in_valid = 1'b1;
    q1.push_back(full[7:0]);
    tick();
    bus1.in_valid = 1'b0;
    checks++;
    if ({bus1.done, bus1.out_valid, bus1.cout} !== {2'b11, full[8]})
      $display("FAIL %s done/out_valid/cout: got %b expected %b", name,
               {bus1.done, bus1.out_valid, bus1.cout}, {2'b11, full[8]});
    else passes++;
`ifdef BSA_OVERFLOW_EN
    checks++;
    if (bus1.ovf !== exp_ovf)
      $display("FAIL %s ovf: got %b expected %b", name, bus1.ovf, exp_ovf);
    else passes++;
`endif
    tick();
    checks++;
    if ({bus1.busy, bus1.done, bus1.cout} !== {2'b00, full[8]})
      $display("FAIL %s after busy/done/cout: got %b expected %b", name,
               {bus1.busy, bus1.done, bus1.cout}, {2'b00, full[8]});
    else passes++;
`ifdef BSA_OVERFLOW_EN
    checks++;
    if (bus1.ovf !== exp_ovf)
      $display("FAIL %s ovf hold: got %b expected %b", name, bus1.ovf, exp_ovf);
    else passes++;
`endif
  endtask

  initial begin
    test_reset();
    run_op("T1", 32'h0000_00FF, 32'h0000_0001, 1'b0, -1, 0);
    run_op("T2", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, -1, 0);
    run_op("T3", 32'h0, 32'h0, 1'b1, -1, 0);
    run_op("T4_stall", 32'h0000_00FF, 32'h0000_0001, 1'b0, 0, 3);
    run_op("signed_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1, 2);
    test_reset_mid();
    run_single("T6a", 8'h7F, 8'h01, 1'b0, 1'b1);
    run_single("T6b", 8'h80, 8'h80, 1'b0, 1'b1);
    run_single("single_cin", 8'h12, 8'h34, 1'b1, 1'b0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
